// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load bus between the IF stage / loader and the instruction memory.
// The master drives requests and load data; the slave is the memory itself.
interface instr_mem_loadable_if #(
    parameter int DEPTH = 256
) ();
    localparam int AW = $clog2(DEPTH);

    logic          fetch_en;
    logic [31:0]   fetch_addr;
    logic          flush;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          fetch_fault;
    logic          load_mode;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [AW:0]   load_count;
    logic          ready;

    modport master (
        output fetch_en, fetch_addr, flush, load_mode, load_we, load_addr, load_data,
        input  instr, instr_valid, fetch_fault, load_count, ready
    );

    modport slave (
        input  fetch_en, fetch_addr, flush, load_mode, load_we, load_addr, load_data,
        output instr, instr_valid, fetch_fault, load_count, ready
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Instruction memory with a registered 1-cycle fetch, stall hold, flush-to-NOP and a run-time
// program-load port. After reset an INIT sweep fills every word with NOP_WORD before fetch starts.
module instr_mem_loadable #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_mem_loadable_if.slave bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_LOAD
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          fault_q, fault_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic [AW-1:0] fetch_idx;
    logic          misaligned;
    logic          out_of_range;
    logic          load_in_range;

    assign fetch_idx     = bus.fetch_addr[AW+1:2];
    assign misaligned    = bus.fetch_addr[1:0] != 2'b00;
    assign out_of_range  = (bus.fetch_addr[31:AW+2] != '0) || ({1'b0, fetch_idx} >= DEPTH_W);
    assign load_in_range = {1'b0, bus.load_addr} < DEPTH_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately unreset; the INIT sweep is what gives it known contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  if (ptr_q == LAST_IDX) state_d = S_RUN;
            S_RUN:   if (bus.load_mode)     state_d = S_LOAD;
            S_LOAD:  if (!bus.load_mode)    state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // The cycle that requests LOAD already kills the fetch, so LOAD outputs show from its first cycle.
    always_comb begin
        ptr_d     = '0;
        instr_d   = instr_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = bus.load_addr;
        mem_wdata = bus.load_data;
        unique case (state_q)
            S_INIT: begin
                ptr_d     = ptr_q + PTR_ONE;
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = NOP_WORD;
                instr_d   = NOP_WORD;
                valid_d   = 1'b0;
                fault_d   = 1'b0;
            end
            S_RUN: begin
                if (bus.load_mode) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    count_d = '0;
                end else if (bus.flush) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                end else if (bus.fetch_en) begin
                    if (misaligned || out_of_range) begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                        fault_d = 1'b1;
                    end else begin
                        instr_d = mem_q[fetch_idx];
                        valid_d = 1'b1;
                        fault_d = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                fault_d = 1'b0;
                if (bus.load_we && load_in_range) begin
                    mem_we = 1'b1;
                    if (count_q != DEPTH_W) begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
            default: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                fault_d = 1'b0;
            end
        endcase
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_fault = fault_q;
    assign bus.load_count  = count_q;
    assign bus.ready       = (state_q == S_RUN);
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: stimulus queues cycle-stamped expectations, a monitor
// compares every output after each rising edge. DEPTH=200 so out-of-range load addresses are reachable.
module tb_instr_mem_loadable;
    localparam int          DEPTH = 200;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic        ready;
        logic [AW:0] count;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] prog [4] = '{32'h00A0_0093, 32'h0140_0113, 32'h0011_21B3, 32'h0001_9663};

    always #5 clk = ~clk;

    instr_mem_loadable_if #(.DEPTH(DEPTH)) bus ();

    instr_mem_loadable #(
        .DEPTH   (DEPTH),
        .NOP_WORD(NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input int fe, input int fa, input int fl, input int lm,
                                  input int we, input int la, input logic [31:0] ld);
        bus.fetch_en   = 1'(fe);
        bus.fetch_addr = 32'(fa);
        bus.flush      = 1'(fl);
        bus.load_mode  = 1'(lm);
        bus.load_we    = 1'(we);
        bus.load_addr  = AW'(la);
        bus.load_data  = ld;
    endtask

    // Expected outputs visible just after the off-th rising edge from now.
    task automatic push_at(input int off, input string name, input logic [31:0] i,
                           input int v, input int f, input int r, input int cnt);
        exp_t e;
        e.cyc   = cyc + off;
        e.name  = name;
        e.instr = i;
        e.valid = 1'(v);
        e.fault = 1'(f);
        e.ready = 1'(r);
        e.count = (AW+1)'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        checks++;
        if (bus.instr !== e.instr || bus.instr_valid !== e.valid || bus.fetch_fault !== e.fault ||
            bus.ready !== e.ready || bus.load_count !== e.count) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got instr=%h valid=%b fault=%b ready=%b count=%0d expected instr=%h valid=%b fault=%b ready=%b count=%0d",
                     e.name, cyc, bus.instr, bus.instr_valid, bus.fetch_fault, bus.ready, bus.load_count,
                     e.instr, e.valid, e.fault, e.ready, e.count);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0);
        step();
        step();

        // Reset values and sweep length.
        push_at(1, "reset_state", NOP, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        push_at(DEPTH - 1, "init_not_ready", NOP, 0, 0, 0, 0);
        push_at(DEPTH, "init_ready_rise", NOP, 0, 0, 1, 0);
        repeat (DEPTH) step();

        apply_stimulus(1, 32'h31C, 0, 0, 0, 0, 32'h0);
        push_at(1, "fetch_last_word_nop", NOP, 1, 0, 1, 0);
        step();
        apply_stimulus(1, 32'h320, 0, 0, 0, 0, 32'h0);
        push_at(1, "fault_idx_eq_depth", NOP, 0, 1, 1, 0);
        step();

        // Program load, then back-to-back fetch.
        apply_stimulus(0, 0, 0, 1, 0, 0, 32'h0);
        push_at(1, "load_entry", NOP, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 0, 1, 1, i, prog[i]);
            push_at(1, "load_write", NOP, 0, 0, 0, i + 1);
            step();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0);
        push_at(1, "load_exit", NOP, 0, 0, 1, 4);
        step();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, i * 4, 0, 0, 0, 0, 32'h0);
            push_at(1, "fetch_prog", prog[i], 1, 0, 1, 4);
            step();
        end

        // Stall hold then flush (flush wins over fetch_en).
        apply_stimulus(1, 32'h8, 0, 0, 0, 0, 32'h0);
        push_at(1, "fetch_8", prog[2], 1, 0, 1, 4);
        step();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 32'h4, 0, 0, 0, 0, 32'h0);
            push_at(1, "stall_hold", prog[2], 1, 0, 1, 4);
            step();
        end
        apply_stimulus(1, 32'h4, 1, 0, 0, 0, 32'h0);
        push_at(1, "flush_wins", NOP, 0, 0, 1, 4);
        step();

        // Faults.
        apply_stimulus(1, 32'h6, 0, 0, 0, 0, 32'h0);
        push_at(1, "misaligned", NOP, 0, 1, 1, 4);
        step();
        apply_stimulus(0, 32'h0, 0, 0, 0, 0, 32'h0);
        push_at(1, "stall_hold_fault", NOP, 0, 1, 1, 4);
        step();
        apply_stimulus(1, 32'h400, 0, 0, 0, 0, 32'h0);
        push_at(1, "upper_out_of_range", NOP, 0, 1, 1, 4);
        step();
        apply_stimulus(1, 32'h4, 0, 0, 0, 0, 32'h0);
        push_at(1, "fetch_after_fault", prog[1], 1, 0, 1, 4);
        step();
        apply_stimulus(0, 32'h4, 1, 0, 0, 0, 32'h0);
        push_at(1, "flush_no_fetch", NOP, 0, 0, 1, 4);
        step();

        // Count clears on entry, out-of-range writes dropped, count saturates at DEPTH.
        apply_stimulus(0, 0, 0, 1, 0, 0, 32'h0);
        push_at(1, "reload_entry_clear", NOP, 0, 0, 0, 0);
        step();
        apply_stimulus(0, 0, 0, 1, 1, 250, 32'hDEAD_BEEF);
        push_at(1, "oob_load_dropped", NOP, 0, 0, 0, 0);
        step();
        for (int i = 0; i <= DEPTH; i++) begin
            apply_stimulus(0, 0, 0, 1, 1, i % DEPTH, 32'hA000_0000 + 32'(i));
            push_at(1, "load_saturate", NOP, 0, 0, 0, (i + 1 > DEPTH) ? DEPTH : i + 1);
            step();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0);
        push_at(1, "reload_exit", NOP, 0, 0, 1, DEPTH);
        step();
        apply_stimulus(0, 0, 0, 0, 1, 7, 32'h0);
        push_at(1, "run_ignores_we", NOP, 0, 0, 1, DEPTH);
        step();
        apply_stimulus(1, 32'h0, 0, 0, 0, 0, 32'h0);
        push_at(1, "readback_word0", 32'hA000_00C8, 1, 0, 1, DEPTH);
        step();
        apply_stimulus(1, 32'h1C, 0, 0, 0, 0, 32'h0);
        push_at(1, "readback_word7", 32'hA000_0007, 1, 0, 1, DEPTH);
        step();

        // Reset mid-sweep restarts the sweep from zero.
        apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b0;
        push_at(1, "reset_clears", NOP, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        repeat (100) step();
        rst_n = 1'b0;
        push_at(1, "reset_mid_sweep", NOP, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        push_at(DEPTH - 1, "resweep_not_ready", NOP, 0, 0, 0, 0);
        push_at(DEPTH, "resweep_ready_rise", NOP, 0, 0, 1, 0);
        repeat (DEPTH) step();
        apply_stimulus(1, 32'h1C, 0, 0, 0, 0, 32'h0);
        push_at(1, "cleared_after_sweep", NOP, 1, 0, 1, 0);
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0);
        step();
        step();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_expectations got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
